next_pc_unit: RTL
=================

// Module: next_pc_unit
// PURPOSE
//  Computes the next program counter value and drives it into the program counter's new_count input.
//  Selects between sequential, branch, jump, jump-register and exception targets.
//  Holds the PC during pipeline stalls, and latches any redirect requested during a stall so it is not lost.
//  Records the EPC and the exception cause.
// PARAMETERS
//  RESET_VECTOR  32'h0000_0000  next_pc value driven while reset is high
//  EXC_VECTOR    32'h0000_0180  exception handler entry address
// PORTS
//  clk             in   1   single clock, rising edge
//  reset           in   1   synchronous, active-high
//  current_count   in   32  present PC (program counter output)
//  stall           in   1   hold PC this cycle
//  branch_taken    in   1   conditional branch resolved taken
//  branch_offset   in   16  signed word offset (I-type imm)
//  jump            in   1   J/JAL
//  jump_target     in   26  J-type target field
//  jump_reg        in   1   JR/JALR
//  reg_target      in   32  register value for JR/JALR
//  exception       in   1   external/execute exception request
//  next_pc         out  32  next PC, wired to program counter new_count
//  redirect_pending out 1   registered; 1 while a stalled redirect is held
//  epc             out  32  registered; PC of the faulting instruction
//  cause           out  2   registered; 0 none, 1 external, 2 misaligned JR
// BEHAVIOUR
//  - One clock (clk); reset is synchronous and active-high.
//  - Reset (sampled at posedge):
//    - state=RUN, redirect_pending=0, pending_target=0, epc=0, cause=0.
//    - next_pc=RESET_VECTOR combinationally while reset is high.
//  - Arithmetic, all modulo 2^32:
//    - pc4 = current_count + 4; 32'hFFFF_FFFC wraps to 0.
//    - br_tgt = pc4 + {{14{branch_offset[15]}}, branch_offset, 2'b00}.
//    - j_tgt = {pc4[31:28], jump_target, 2'b00}.
//  - Misaligned JR: jump_reg=1 and reg_target[1:0]!=0 is treated as an exception with cause=2.
//  - Request priority, highest first:
//    1. exception
//    2. misaligned JR
//    3. jump_reg
//    4. jump
//    5. branch_taken
//    6. sequential (pc4)
//  - next_pc is combinational (zero latency); the program counter register provides the single cycle of latency.
//  - FSM states:
//    - RUN:
//      - stall=0: next_pc = selected target.
//      - stall=1: next_pc = current_count. A non-exception redirect this cycle stores its target in pending_target, sets redirect_pending, and moves to HOLD.
//    - HOLD:
//      - stall=1: next_pc = current_count; the held target is kept. New non-exception redirects are ignored (first redirect wins).
//      - stall=0: next_pc = pending_target; redirect_pending clears and state returns to RUN. Redirect inputs on this cycle are ignored.
//  - Exceptions (external or misaligned JR), in any state, stalled or not:
//    - Override the stall: next_pc = EXC_VECTOR.
//    - On the next edge: epc <= current_count, cause <= 1 or 2, pending is cleared, state returns to RUN.
//  - cause and epc hold their values until the next exception or reset (software-visible).
//  - Reset mid-HOLD discards the pending target; there is no redirect after reset.
// STRUCTURE
//  - Shared package cpu_pkg holds:
//    - RESET_VECTOR and EXC_VECTOR defaults.
//    - Cause codes CAUSE_NONE/EXT/MISALIGN.
//    - FSM state encoding PC_RUN, PC_HOLD.
//  - Sub-module pc_target_calc (combinational): computes pc4, br_tgt, j_tgt and the misaligned flag.
//  - next_pc_unit contains the priority mux, the FSM and the epc/cause registers.
// TESTING
//  1. Reset, then release with current_count=0 and no requests -> next_pc=4.
//     With current_count=32'hFFFF_FFFC -> next_pc=0.
//  2. Branch: pc=0x100, branch_taken=1, offset=16'hFFFF -> next_pc=0x100.
//     Branch: offset=16'h0003 -> next_pc=0x110.
//  3. Jump: pc=0x4000_0010, jump=1, target=26'h000_0040 -> next_pc=0x4000_0100.
//     Same cycle with branch_taken=1 -> jump wins.
//  4. Stalled redirect: stall=1 with jump=1 to 0x200 at pc=0x80:
//     - next_pc=0x80, redirect_pending=1.
//     - Stall 2 more cycles with branch_taken=1 -> held target stays 0x200.
//     - stall=0 -> next_pc=0x200, then redirect_pending=0.
//  5. Misaligned JR: jump_reg=1, reg_target=0x102, pc=0x50 -> next_pc=0x180; next cycle epc=0x50, cause=2.
//     External exception with stall=1 -> next_pc=0x180, cause=1.
//  6. Reset asserted in HOLD -> next_pc=0; after release redirect_pending=0, epc=0, cause=0, next_pc=4 at pc=0.

Source files
------------

// File: rtl/cpu_pkg.sv
// ---------------------------------------------------------------------------
// cpu_pkg
//   Shared definitions for the next-PC logic:
//     - default reset and exception vectors
//     - exception cause codes (software-visible encoding)
//     - next-PC FSM state encoding
//     - bundle of precomputed candidate targets
// ---------------------------------------------------------------------------
package cpu_pkg;

    // Default vectors; the top module exposes these as overridable parameters.
    localparam logic [31:0] DEF_RESET_VECTOR = 32'h0000_0000;
    localparam logic [31:0] DEF_EXC_VECTOR   = 32'h0000_0180;

    // Exception cause codes as seen by software.
    typedef enum logic [1:0] {
        CAUSE_NONE     = 2'd0,
        CAUSE_EXT      = 2'd1,
        CAUSE_MISALIGN = 2'd2
    } cause_e;

    // RUN: normal operation. HOLD: a redirect arrived during a stall and is
    // waiting for the stall to drop.
    typedef enum logic {
        PC_RUN  = 1'b0,
        PC_HOLD = 1'b1
    } pc_state_e;

    // Candidate targets produced by the address arithmetic.
    typedef struct packed {
        logic [31:0] pc4;
        logic [31:0] br_tgt;
        logic [31:0] j_tgt;
        logic        misaligned;
    } targets_t;

endpackage : cpu_pkg

// File: rtl/pc_target_calc.sv
// ---------------------------------------------------------------------------
// pc_target_calc
//   Purely combinational address arithmetic for the next-PC unit.
//   All sums are modulo 2^32.
// Ports
//   current_count_i   in  32  present PC
//   branch_offset_i   in  16  signed word offset (I-type immediate)
//   jump_target_i     in  26  J-type target field
//   jump_reg_i        in  1   JR/JALR request
//   reg_target_lo_i   in  2   low bits of the JR/JALR register value
//   targets_o         out     pc4, branch target, jump target, misaligned flag
// ---------------------------------------------------------------------------
module pc_target_calc
    import cpu_pkg::*;
(
    input  logic [31:0] current_count_i,
    input  logic [15:0] branch_offset_i,
    input  logic [25:0] jump_target_i,
    input  logic        jump_reg_i,
    input  logic [1:0]  reg_target_lo_i,
    output targets_t    targets_o
);

    logic [31:0] pc4;
    logic [31:0] br_disp;

    // Sequential address; 32'hFFFF_FFFC wraps to 0 naturally.
    assign pc4 = current_count_i + 32'd4;

    // Word offset sign-extended and scaled to bytes.
    assign br_disp = {{14{branch_offset_i[15]}}, branch_offset_i, 2'b00};

    assign targets_o.pc4        = pc4;
    assign targets_o.br_tgt     = pc4 + br_disp;
    // Jumps stay inside the 256 MB region of the delay-slot address.
    assign targets_o.j_tgt      = {pc4[31:28], jump_target_i, 2'b00};
    // A register jump to a non-word address is an exception, not a redirect.
    assign targets_o.misaligned = jump_reg_i && (reg_target_lo_i != 2'b00);

endmodule : pc_target_calc

// File: rtl/next_pc_unit.sv
// ---------------------------------------------------------------------------
// next_pc_unit
//   Selects the next program counter value (sequential, branch, jump,
//   jump-register or exception vector) and drives it combinationally into
//   the program counter's new_count input. Holds the PC while stalled and
//   remembers the first redirect seen during a stall so it is applied once
//   the stall drops. Records EPC and cause on every exception.
// Parameters
//   RESET_VECTOR      next_pc while reset is high
//   EXC_VECTOR        exception handler entry
// Ports
//   clk               in   1   rising-edge clock
//   reset             in   1   synchronous, active-high
//   current_count     in   32  present PC
//   stall             in   1   hold PC this cycle
//   branch_taken      in   1   conditional branch resolved taken
//   branch_offset     in   16  signed word offset
//   jump              in   1   J/JAL
//   jump_target       in   26  J-type target field
//   jump_reg          in   1   JR/JALR
//   reg_target        in   32  register target for JR/JALR
//   exception         in   1   external/execute exception request
//   next_pc           out  32  next PC (combinational)
//   redirect_pending  out  1   registered; a stalled redirect is held
//   epc               out  32  registered; PC of the faulting instruction
//   cause             out  2   registered; 0 none, 1 external, 2 misaligned JR
// ---------------------------------------------------------------------------
module next_pc_unit
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = DEF_RESET_VECTOR,
    parameter logic [31:0] EXC_VECTOR   = DEF_EXC_VECTOR
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] current_count,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [15:0] branch_offset,
    input  logic        jump,
    input  logic [25:0] jump_target,
    input  logic        jump_reg,
    input  logic [31:0] reg_target,
    input  logic        exception,
    output logic [31:0] next_pc,
    output logic        redirect_pending,
    output logic [31:0] epc,
    output logic [1:0]  cause
);

    targets_t    tgt;

    pc_state_e   state_q,          state_d;
    logic [31:0] pending_target_q, pending_target_d;
    logic [31:0] epc_q,            epc_d;
    cause_e      cause_q,          cause_d;

    logic        exc_take;
    logic        redirect_req;
    logic [31:0] redirect_tgt;
    logic [31:0] run_tgt;

    // ------------------------------------------------------------------
    // Address arithmetic
    // ------------------------------------------------------------------
    pc_target_calc u_target_calc (
        .current_count_i (current_count),
        .branch_offset_i (branch_offset),
        .jump_target_i   (jump_target),
        .jump_reg_i      (jump_reg),
        .reg_target_lo_i (reg_target[1:0]),
        .targets_o       (tgt)
    );

    // ------------------------------------------------------------------
    // Request priority: exception > misaligned JR > JR > J > branch > pc4
    // ------------------------------------------------------------------
    assign exc_take     = exception || tgt.misaligned;
    assign redirect_req = jump_reg || jump || branch_taken;

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        redirect_tgt = tgt.br_tgt;
        if (jump_reg) begin
            redirect_tgt = reg_target;
        end else if (jump) begin
            redirect_tgt = tgt.j_tgt;
        end
    end

    assign run_tgt = redirect_req ? redirect_tgt : tgt.pc4;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d          = state_q;
        pending_target_d = pending_target_q;
        epc_d            = epc_q;
        cause_d          = cause_q;

        if (exc_take) begin
            // Exceptions win in any state and discard a held redirect.
            epc_d            = current_count;
            cause_d          = exception ? CAUSE_EXT : CAUSE_MISALIGN;
            pending_target_d = '0;
            state_d          = PC_RUN;
        end else begin
            unique case (state_q)
                PC_RUN: begin
                    if (stall && redirect_req) begin
                        pending_target_d = redirect_tgt;
                        state_d          = PC_HOLD;
                    end
                end
                PC_HOLD: begin
                    // First redirect wins; later requests are dropped.
                    if (!stall) begin
                        pending_target_d = '0;
                        state_d          = PC_RUN;
                    end
                end
                default: begin
                    state_d = PC_RUN;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Output mux (combinational, zero latency)
    // ------------------------------------------------------------------
    always_comb begin
        next_pc = current_count;
        if (reset) begin
            next_pc = RESET_VECTOR;
        end else if (exc_take) begin
            next_pc = EXC_VECTOR;
        end else if (!stall) begin
            next_pc = (state_q == PC_HOLD) ? pending_target_q : run_tgt;
        end
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples the
        // values from before the edge, independent of statement order.
        if (reset) begin
            state_q          <= PC_RUN;
            // NOTE: the held target is reset too, even though the state
            // gates its use, so no X can ever reach next_pc.
            pending_target_q <= '0;
            epc_q            <= '0;
            cause_q          <= CAUSE_NONE;
        end else begin
            state_q          <= state_d;
            pending_target_q <= pending_target_d;
            epc_q            <= epc_d;
            cause_q          <= cause_d;
        end
    end

    assign redirect_pending = (state_q == PC_HOLD);
    assign epc              = epc_q;
    assign cause            = cause_q;

endmodule : next_pc_unit
